// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } md_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_bubble;
   } ctrl_t;

   // While in reset the front end is frozen and everything downstream is a nop.
   localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1, id_ex_bubble: 1'b1};
   localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
   localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b1};
   localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b1};

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave the hazard unit.
interface hazard_control_unit_if #(parameter int CNT_W = 16);
   logic             ID_EX_MemRead;
   logic [4:0]       ID_EX_RegRt;
   logic [4:0]       IF_ID_Rs;
   logic [4:0]       IF_ID_Rt;
   logic             IF_ID_UsesRt;
   logic             IF_ID_HiLo;
   logic             ID_EX_MulDiv;
   logic             EX_BranchTaken;
   logic             ID_Jump;
   logic             PCWrite;
   logic             IF_ID_Write;
   logic             IF_ID_Flush;
   logic             ID_EX_Bubble;
   logic             MD_Busy;
   logic             MD_Done;
   logic [CNT_W-1:0] StallCount;
   logic [CNT_W-1:0] FlushCount;

   modport master (
      output ID_EX_MemRead, ID_EX_RegRt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt,
             IF_ID_HiLo, ID_EX_MulDiv, EX_BranchTaken, ID_Jump,
      input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble,
             MD_Busy, MD_Done, StallCount, FlushCount
   );

   modport slave (
      input  ID_EX_MemRead, ID_EX_RegRt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt,
             IF_ID_HiLo, ID_EX_MulDiv, EX_BranchTaken, ID_Jump,
      output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble,
             MD_Busy, MD_Done, StallCount, FlushCount
   );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating event counter used for the stall/flush performance counters.
module hazard_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Inc,
   output logic [WIDTH-1:0] Count
);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         Count <= '0;
      else if (Inc && (Count != '1))
         Count <= Count + 1'b1;
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Front-end sequencing: load-use and HI/LO stalls, branch/jump flushes, mult/div occupancy.
module hazard_control_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int MD_LATENCY = 32,
   parameter int CNT_W      = 16
) (
   input logic                  Clk,
   input logic                  Rst_n,
   hazard_control_unit_if.slave hz
);

   md_state_e        state;
   logic [7:0]       md_cnt;
   logic             md_busy;
   logic             md_done;
   logic             load_use;
   logic             md_haz;
   ctrl_t            ctrl;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   assign load_use = hz.ID_EX_MemRead && (hz.ID_EX_RegRt != REG_ZERO) &&
                     ((hz.ID_EX_RegRt == hz.IF_ID_Rs) ||
                      (hz.IF_ID_UsesRt && (hz.ID_EX_RegRt == hz.IF_ID_Rt)));
   assign md_haz   = (state == MD_WAIT) && hz.IF_ID_HiLo;

   // A taken branch squashes the stalled instruction, so it outranks any stall.
   always_comb begin
      ctrl = CTRL_RUN;
      if (!Rst_n)
         ctrl = CTRL_RESET;
      else if (hz.EX_BranchTaken)
         ctrl = CTRL_BRANCH;
      else if (md_haz || load_use)
         ctrl = CTRL_STALL;
      else if (hz.ID_Jump)
         ctrl.if_id_flush = 1'b1;
   end

   // Start in MD_WAIT is ignored; the counter counts down to the completion edge.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state   <= RUN;
         md_cnt  <= '0;
         md_busy <= 1'b0;
         md_done <= 1'b0;
      end else begin
         md_done <= 1'b0;
         case (state)
            RUN: begin
               if (hz.ID_EX_MulDiv) begin
                  state   <= MD_WAIT;
                  md_cnt  <= 8'(MD_LATENCY - 1);
                  md_busy <= 1'b1;
               end
            end
            MD_WAIT: begin
               if (md_cnt == '0) begin
                  state   <= RUN;
                  md_busy <= 1'b0;
                  md_done <= 1'b1;
               end else begin
                  md_cnt <= md_cnt - 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   hazard_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .Inc   (!ctrl.pc_write),
      .Count (stall_cnt)
   );

   hazard_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .Inc   (ctrl.if_id_flush),
      .Count (flush_cnt)
   );

   assign hz.PCWrite      = ctrl.pc_write;
   assign hz.IF_ID_Write  = ctrl.if_id_write;
   assign hz.IF_ID_Flush  = ctrl.if_id_flush;
   assign hz.ID_EX_Bubble = ctrl.id_ex_bubble;
   assign hz.MD_Busy      = md_busy;
   assign hz.MD_Done      = md_done;
   assign hz.StallCount   = stall_cnt;
   assign hz.FlushCount   = flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with MD_LATENCY=4, CNT_W=3.
module tb_hazard_control_unit;

   localparam int MD_LAT = 4;
   localparam int CW     = 3;

   logic Clk = 1'b0;
   logic Rst_n;
   int   npass = 0;
   int   ntot  = 0;

   hazard_control_unit_if #(.CNT_W(CW)) hz ();

   hazard_control_unit #(.MD_LATENCY(MD_LAT), .CNT_W(CW)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .hz    (hz.slave)
   );

   always #5 Clk = ~Clk;

   // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}
   logic [3:0] ctl;
   assign ctl = {hz.PCWrite, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Bubble};

   task automatic clear_inputs();
      hz.ID_EX_MemRead  = 1'b0;
      hz.ID_EX_RegRt    = 5'd0;
      hz.IF_ID_Rs       = 5'd0;
      hz.IF_ID_Rt       = 5'd0;
      hz.IF_ID_UsesRt   = 1'b0;
      hz.IF_ID_HiLo     = 1'b0;
      hz.ID_EX_MulDiv   = 1'b0;
      hz.EX_BranchTaken = 1'b0;
      hz.ID_Jump        = 1'b0;
   endtask

   // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      Rst_n = 1'b0;
      step();
      step();
      Rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      hz.EX_BranchTaken = 1'b1;
      Rst_n = 1'b0;
      #2;
      ntot++; if (ctl !== 4'b0011) $display("FAIL reset_ctrl got=%b exp=0011", ctl); else npass++;
      ntot++; if ({hz.MD_Busy, hz.MD_Done} !== 2'b00) $display("FAIL reset_md got=%b exp=00", {hz.MD_Busy, hz.MD_Done}); else npass++;
      ntot++; if (hz.StallCount !== 3'd0 || hz.FlushCount !== 3'd0)
         $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hz.StallCount, hz.FlushCount); else npass++;
      do_reset();
      ntot++; if (ctl !== 4'b1100) $display("FAIL reset_idle got=%b exp=1100", ctl); else npass++;
   endtask

   task automatic test_load_use();
      do_reset();
      hz.ID_EX_MemRead = 1'b1; hz.ID_EX_RegRt = 5'd8; hz.IF_ID_Rs = 5'd8;
      #1;
      ntot++; if (ctl !== 4'b0001) $display("FAIL lu_stall got=%b exp=0001", ctl); else npass++;
      step();
      hz.ID_EX_MemRead = 1'b0;
      #1;
      ntot++; if (hz.StallCount !== 3'd1) $display("FAIL lu_cnt got=%0d exp=1", hz.StallCount); else npass++;
      ntot++; if (ctl !== 4'b1100) $display("FAIL lu_release got=%b exp=1100", ctl); else npass++;
      hz.ID_EX_MemRead = 1'b1; hz.ID_EX_RegRt = 5'd0; hz.IF_ID_Rs = 5'd0;
      #1;
      ntot++; if (ctl !== 4'b1100) $display("FAIL lu_zero got=%b exp=1100", ctl); else npass++;
      step();
      ntot++; if (hz.StallCount !== 3'd1) $display("FAIL lu_zero_cnt got=%0d exp=1", hz.StallCount); else npass++;
      clear_inputs();
   endtask

   task automatic test_rt_gating();
      hz.ID_EX_MemRead = 1'b1; hz.ID_EX_RegRt = 5'd8; hz.IF_ID_Rs = 5'd3; hz.IF_ID_Rt = 5'd8;
      hz.IF_ID_UsesRt = 1'b0;
      #1;
      ntot++; if (ctl !== 4'b1100) $display("FAIL rt_unused got=%b exp=1100", ctl); else npass++;
      hz.IF_ID_UsesRt = 1'b1;
      #1;
      ntot++; if (ctl !== 4'b0001) $display("FAIL rt_used got=%b exp=0001", ctl); else npass++;
      step();
      ntot++; if (hz.StallCount !== 3'd2) $display("FAIL rt_cnt got=%0d exp=2", hz.StallCount); else npass++;
      clear_inputs();
   endtask

   task automatic test_branch_jump();
      hz.ID_EX_MemRead = 1'b1; hz.ID_EX_RegRt = 5'd8; hz.IF_ID_Rs = 5'd8; hz.EX_BranchTaken = 1'b1;
      #1;
      ntot++; if (ctl !== 4'b1111) $display("FAIL br_over_stall got=%b exp=1111", ctl); else npass++;
      step();
      clear_inputs();
      ntot++; if (hz.FlushCount !== 3'd1 || hz.StallCount !== 3'd2)
         $display("FAIL br_cnt got=%0d/%0d exp=1/2", hz.FlushCount, hz.StallCount); else npass++;
      hz.ID_Jump = 1'b1;
      #1;
      ntot++; if (ctl !== 4'b1110) $display("FAIL jump got=%b exp=1110", ctl); else npass++;
      step();
      ntot++; if (hz.FlushCount !== 3'd2) $display("FAIL jump_cnt got=%0d exp=2", hz.FlushCount); else npass++;
      hz.ID_EX_MemRead = 1'b1; hz.ID_EX_RegRt = 5'd9; hz.IF_ID_Rs = 5'd9;
      #1;
      ntot++; if (ctl !== 4'b0001) $display("FAIL stall_over_jump got=%b exp=0001", ctl); else npass++;
      step();
      ntot++; if (hz.FlushCount !== 3'd2 || hz.StallCount !== 3'd3)
         $display("FAIL soj_cnt got=%0d/%0d exp=2/3", hz.FlushCount, hz.StallCount); else npass++;
      clear_inputs();
   endtask

   task automatic test_muldiv();
      do_reset();
      hz.ID_EX_MulDiv = 1'b1;
      #1;
      ntot++; if (ctl !== 4'b1100 || hz.MD_Busy !== 1'b0) $display("FAIL md_pre got=%b busy=%b exp=1100 busy=0", ctl, hz.MD_Busy); else npass++;
      step();
      hz.ID_EX_MulDiv = 1'b0; hz.IF_ID_HiLo = 1'b1;
      for (int i = 0; i < MD_LAT; i++) begin
         #1;
         ntot++; if ({hz.MD_Busy, hz.MD_Done, ctl} !== 6'b10_0001)
            $display("FAIL md_busy[%0d] got=%b exp=100001", i, {hz.MD_Busy, hz.MD_Done, ctl}); else npass++;
         step();
      end
      #1;
      ntot++; if ({hz.MD_Busy, hz.MD_Done, ctl} !== 6'b01_1100)
         $display("FAIL md_done got=%b exp=011100", {hz.MD_Busy, hz.MD_Done, ctl}); else npass++;
      ntot++; if (hz.StallCount !== 3'd4) $display("FAIL md_stall_cnt got=%0d exp=4", hz.StallCount); else npass++;
      // second mult/div enters EX in the done cycle; repeated starts while busy are ignored
      hz.ID_EX_MulDiv = 1'b1; hz.IF_ID_HiLo = 1'b0;
      step();
      for (int i = 0; i < MD_LAT; i++) begin
         if (i == MD_LAT - 1) hz.ID_EX_MulDiv = 1'b0;
         #1;
         ntot++; if ({hz.MD_Busy, hz.MD_Done} !== 2'b10)
            $display("FAIL b2b_busy[%0d] got=%b exp=10", i, {hz.MD_Busy, hz.MD_Done}); else npass++;
         step();
      end
      ntot++; if ({hz.MD_Busy, hz.MD_Done} !== 2'b01)
         $display("FAIL b2b_done got=%b exp=01", {hz.MD_Busy, hz.MD_Done}); else npass++;
      step();
      ntot++; if ({hz.MD_Busy, hz.MD_Done} !== 2'b00)
         $display("FAIL b2b_idle got=%b exp=00", {hz.MD_Busy, hz.MD_Done}); else npass++;
      clear_inputs();
   endtask

   task automatic test_saturation();
      do_reset();
      hz.ID_EX_MemRead = 1'b1; hz.ID_EX_RegRt = 5'd5; hz.IF_ID_Rs = 5'd5;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (i == 6) begin
            ntot++; if (hz.StallCount !== 3'd6) $display("FAIL sat_mid got=%0d exp=6", hz.StallCount); else npass++;
         end
      end
      ntot++; if (hz.StallCount !== 3'd7) $display("FAIL sat_hold got=%0d exp=7", hz.StallCount); else npass++;
      clear_inputs();
   endtask

   task automatic test_reset_mid_md();
      do_reset();
      hz.EX_BranchTaken = 1'b1;
      step();
      hz.EX_BranchTaken = 1'b0; hz.ID_EX_MulDiv = 1'b1;
      step();
      hz.ID_EX_MulDiv = 1'b0; hz.IF_ID_HiLo = 1'b1;
      step();
      step();
      ntot++; if (hz.MD_Busy !== 1'b1 || hz.StallCount !== 3'd2 || hz.FlushCount !== 3'd1)
         $display("FAIL rmd_pre got=busy%b %0d/%0d exp=busy1 2/1", hz.MD_Busy, hz.StallCount, hz.FlushCount); else npass++;
      #2;
      Rst_n = 1'b0;
      #1;
      ntot++; if (hz.MD_Busy !== 1'b0 || hz.StallCount !== 3'd0 || hz.FlushCount !== 3'd0)
         $display("FAIL rmd_async got=busy%b %0d/%0d exp=busy0 0/0", hz.MD_Busy, hz.StallCount, hz.FlushCount); else npass++;
      ntot++; if (ctl !== 4'b0011) $display("FAIL rmd_ctrl got=%b exp=0011", ctl); else npass++;
      step();
      Rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         ntot++; if ({hz.MD_Busy, hz.MD_Done, ctl} !== 6'b00_1100)
            $display("FAIL rmd_after[%0d] got=%b exp=001100", i, {hz.MD_Busy, hz.MD_Done, ctl}); else npass++;
         step();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      Rst_n = 1'b1;
      test_reset();
      test_load_use();
      test_rt_gating();
      test_branch_jump();
      test_muldiv();
      test_saturation();
      test_reset_mid_md();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
